// File: rtl/uart_loader.sv
// uart_loader: drains the UART wrapper's RX FIFO, parses SYNC/ADDR/LEN/payload/CHK
// frames, writes the payload to a byte-wide memory port and replies ACK or NAK.
module uart_loader #(
  parameter int         ADDR_W  = 16,
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter logic [7:0] ACK     = 8'h06,
  parameter logic [7:0] NAK     = 8'h15,
  parameter int         RD_LAT  = 2,
  parameter int         TIMEOUT = 1000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic [15:0]       uartStatus,
  output logic              uartRead,
  output logic              uartWrite,
  output logic [7:0]        uartData,
  output logic [ADDR_W-1:0] memAddr,
  output logic [7:0]        memData,
  output logic              memWrite,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int LAT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_HUNT,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN,
    S_DATA,
    S_CHK,
    S_REPLY
  } state_t;

  state_t            state_q, state_d;
  logic              rd_pend_q, rd_pend_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [7:0]        acc_q, acc_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              good_q, good_d;

  logic              read_d, write_d, mwrite_d, done_d, error_d;
  logic [7:0]        udata_d, mdata_d;
  logic [ADDR_W-1:0] maddr_d;
  logic              timeout_hit;

  logic       rx_empty, tx_full, sample, in_frame;
  logic [7:0] rx_byte, sum;
  logic       unused_status;

  assign rx_empty      = uartStatus[11];
  assign tx_full       = uartStatus[8];
  assign rx_byte       = uartStatus[7:0];
  assign unused_status = ^{uartStatus[15:12], uartStatus[10:9]};

  // The popped byte is valid on uartStatus RD_LAT cycles after the uartRead cycle.
  assign sample   = rd_pend_q && (lat_q == LAT_W'(RD_LAT));
  assign sum      = acc_q + rx_byte;
  assign in_frame = (state_q != S_HUNT) && (state_q != S_REPLY);
  assign busy     = (state_q != S_HUNT);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d     = state_q;
    rd_pend_d   = rd_pend_q;
    lat_d       = lat_q;
    to_d        = to_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    addr_d      = addr_q;
    good_d      = good_q;
    read_d      = 1'b0;
    write_d     = 1'b0;
    mwrite_d    = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;
    udata_d     = uartData;
    mdata_d     = memData;
    maddr_d     = memAddr;
    timeout_hit = 1'b0;

    if (rd_pend_q && !sample) lat_d = lat_q + 1'b1;
    if (sample) rd_pend_d = 1'b0;

    case (state_q)
      S_HUNT: begin
        if (sample && rx_byte == SYNC) state_d = S_ADDR_HI;
      end
      S_ADDR_HI: begin
        if (sample) begin
          hi_d    = rx_byte;
          acc_d   = rx_byte;
          state_d = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (sample) begin
          addr_d  = ADDR_W'({hi_q, rx_byte});
          acc_d   = sum;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (sample) begin
          cnt_d   = rx_byte;
          acc_d   = sum;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (sample) begin
          maddr_d  = addr_q;
          mdata_d  = rx_byte;
          mwrite_d = 1'b1;
          addr_d   = addr_q + 1'b1;
          acc_d    = sum;
          if (cnt_q == 8'd0) state_d = S_CHK;
          else               cnt_d   = cnt_q - 1'b1;
        end
      end
      S_CHK: begin
        if (sample) begin
          good_d  = (sum == 8'd0);
          state_d = S_REPLY;
        end
      end
      S_REPLY: begin
        // uartWrite doubles as the "reply already pushed" flag for the final REPLY cycle.
        if (uartWrite) begin
          state_d = S_HUNT;
        end else if (!tx_full) begin
          write_d = 1'b1;
          udata_d = good_q ? ACK : NAK;
          done_d  = good_q;
          error_d = !good_q;
        end
      end
      default: state_d = S_HUNT;
    endcase

    if (in_frame) begin
      if (sample) begin
        to_d = '0;
      end else if (to_q == TO_W'(TIMEOUT - 1)) begin
        timeout_hit = 1'b1;
        to_d        = '0;
        error_d     = 1'b1;
        rd_pend_d   = 1'b0;
        state_d     = S_HUNT;
      end else begin
        to_d = to_q + 1'b1;
      end
    end else begin
      to_d = '0;
    end

    // Next pop may issue on the sampling edge itself, giving back-to-back fetches.
    if ((!rd_pend_q || sample) && !rx_empty && !timeout_hit &&
        ((state_d inside {S_ADDR_HI, S_ADDR_LO, S_LEN, S_DATA, S_CHK}) ||
         (state_d == S_HUNT && enable))) begin
      read_d    = 1'b1;
      rd_pend_d = 1'b1;
      lat_d     = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (RST) begin
      state_q   <= S_HUNT;
      rd_pend_q <= 1'b0;
      lat_q     <= '0;
      to_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      addr_q    <= '0;
      good_q    <= 1'b0;
      uartRead  <= 1'b0;
      uartWrite <= 1'b0;
      uartData  <= '0;
      memAddr   <= '0;
      memData   <= '0;
      memWrite  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      lat_q     <= lat_d;
      to_q      <= to_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      addr_q    <= addr_d;
      good_q    <= good_d;
      uartRead  <= read_d;
      uartWrite <= write_d;
      uartData  <= udata_d;
      memAddr   <= maddr_d;
      memData   <= mdata_d;
      memWrite  <= mwrite_d;
      done      <= done_d;
      error     <= error_d;
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: models the UART wrapper FIFOs around uart_loader and checks memory
// writes and replies against a frame-level reference parser.
module tb_uart_loader;

  localparam int         RD_LAT  = 2;
  localparam int         TIMEOUT = 100;
  localparam logic [7:0] SYNC    = 8'hA5;
  localparam logic [7:0] ACK     = 8'h06;
  localparam logic [7:0] NAK     = 8'h15;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        enable = 1'b0;
  logic        rx_empty_r = 1'b1;
  logic        tx_full_r = 1'b0;
  logic [7:0]  rx_data_r = 8'h00;
  logic [15:0] uartStatus;
  logic        uartRead, uartWrite, memWrite, busy, done, error;
  logic [7:0]  uartData, memData;
  logic [15:0] memAddr;

  assign uartStatus = {4'b0000, rx_empty_r, 1'b0, ~tx_full_r, tx_full_r, rx_data_r};

  uart_loader #(
    .ADDR_W(16), .SYNC(SYNC), .ACK(ACK), .NAK(NAK), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .uartStatus(uartStatus),
    .uartRead(uartRead), .uartWrite(uartWrite), .uartData(uartData),
    .memAddr(memAddr), .memData(memData), .memWrite(memWrite),
    .busy(busy), .done(done), .error(error)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         due;
    logic [7:0] b;
  } rx_pend_t;

  logic [7:0]  rx_q[$];
  rx_pend_t    dq[$];
  rx_pend_t    pend;
  logic [7:0]  stim[$];
  logic [23:0] wr_log[$], exp_wr[$];
  logic [9:0]  tx_log[$], exp_tx[$];
  int cyc = 0, done_cnt = 0, err_cnt = 0, bad_reads = 0;
  int err_cyc = 0, last_wr_cyc = 0, tx_cyc = 0;
  int checks = 0, passes = 0;

  // Wrapper model: pop on uartRead, present the byte RD_LAT cycles later, log DUT strobes.
  always @(negedge CLK) begin
    cyc++;
    if (uartRead) begin
      if (rx_empty_r || rx_q.size() == 0) bad_reads++;
      else begin
        pend.due = cyc + RD_LAT;
        pend.b   = rx_q.pop_front();
        dq.push_back(pend);
      end
    end
    if (dq.size() > 0 && dq[0].due == cyc) begin
      rx_data_r = dq[0].b;
      void'(dq.pop_front());
    end
    rx_empty_r = (rx_q.size() == 0);
    if (memWrite) begin
      wr_log.push_back({memAddr, memData});
      last_wr_cyc = cyc;
    end
    if (uartWrite) begin
      tx_log.push_back({done, error, uartData});
      tx_cyc = cyc;
    end
    if (done) done_cnt++;
    if (error) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {26'd0, uartRead, uartWrite, memWrite, busy, done, error}, 32'd0);
    check({tag, "_bus"}, {uartData, memData, memAddr}, 32'd0);
  endtask

  task automatic clear_logs();
    wr_log.delete(); exp_wr.delete(); tx_log.delete(); exp_tx.delete();
    done_cnt = 0; err_cnt = 0; bad_reads = 0;
  endtask

  // Reference parser over the whole byte stream: skip non-SYNC bytes, then walk one frame.
  task automatic model();
    int i = 0;
    int n;
    logic [15:0] a;
    logic [7:0]  s;
    while (i < stim.size()) begin
      if (stim[i] != SYNC) i++;
      else begin
        a = {stim[i+1], stim[i+2]};
        n = int'(stim[i+3]) + 1;
        s = stim[i+1] + stim[i+2] + stim[i+3];
        for (int k = 0; k < n; k++) begin
          exp_wr.push_back({a, stim[i+4+k]});
          s = s + stim[i+4+k];
          a = a + 16'd1;
        end
        s = s + stim[i+4+n];
        exp_tx.push_back((s == 8'd0) ? {2'b10, ACK} : {2'b01, NAK});
        i = i + 5 + n;
      end
    end
  endtask

  task automatic add_garbage(input int n);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = 8'($urandom);
      if (b == SYNC) b = 8'h00;
      stim.push_back(b);
    end
  endtask

  task automatic add_frame(input logic [15:0] a, input logic [7:0] len, input bit good);
    logic [7:0] s, b;
    stim.push_back(SYNC); stim.push_back(a[15:8]); stim.push_back(a[7:0]); stim.push_back(len);
    s = a[15:8] + a[7:0] + len;
    for (int k = 0; k <= int'(len); k++) begin
      b = 8'($urandom);
      stim.push_back(b);
      s = s + b;
    end
    if (good) stim.push_back(8'(8'd0 - s));
    else      stim.push_back(8'(8'd0 - s + 8'($urandom_range(1, 255))));
  endtask

  task automatic push_stim();
    foreach (stim[k]) rx_q.push_back(stim[k]);
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    for (int i = 0; i < 4000 && quiet < RD_LAT + 6; i++) begin
      @(posedge CLK); #1;
      if (rx_q.size() == 0 && dq.size() == 0 && !busy && !uartRead) quiet++;
      else quiet = 0;
    end
    check({tag, "_idle"}, 32'(quiet >= RD_LAT + 6), 32'd1);
  endtask

  task automatic compare(input string tag, input int n_to);
    int acks = 0, naks = 0;
    foreach (exp_tx[k]) if (exp_tx[k][7:0] == ACK) acks++; else naks++;
    check({tag, "_nwr"}, wr_log.size(), exp_wr.size());
    for (int k = 0; k < exp_wr.size() && k < wr_log.size(); k++)
      check({tag, "_wr"}, 32'(wr_log[k]), 32'(exp_wr[k]));
    check({tag, "_ntx"}, tx_log.size(), exp_tx.size());
    for (int k = 0; k < exp_tx.size() && k < tx_log.size(); k++)
      check({tag, "_tx"}, 32'(tx_log[k]), 32'(exp_tx[k]));
    check({tag, "_done"}, done_cnt, acks);
    check({tag, "_err"}, err_cnt, naks + n_to);
    check({tag, "_rdempty"}, bad_reads, 0);
  endtask

  task automatic run_stream(input string tag);
    clear_logs();
    model();
    @(posedge CLK); #1;
    push_stim();
    wait_idle(tag);
    compare(tag, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rel;
    RST = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_zero("reset");
    RST = 1'b0;
    enable = 1'b1;

    stim = '{8'hA5, 8'h12, 8'h34, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'h87};
    run_stream("good");
    check("good_w0", (wr_log.size() > 0) ? 32'(wr_log[0]) : 32'd0, 32'h1234AA);
    check("good_ack", (tx_log.size() > 0) ? 32'(tx_log[0]) : 32'd0, 32'h206);

    stim = '{8'hA5, 8'h12, 8'h34, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'h88};
    run_stream("badchk");
    check("badchk_nak", (tx_log.size() > 0) ? 32'(tx_log[0]) : 32'd0, 32'h115);

    stim = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h12, 8'h34, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'h87};
    run_stream("prefix");

    stim = '{8'hA5, 8'hFF, 8'hFF, 8'h01, 8'h11, 8'h22, 8'hCE};
    run_stream("wrap");
    check("wrap_w1", (wr_log.size() > 1) ? 32'(wr_log[1]) : 32'd0, 32'h000022);

    // Frame abandoned after two payload bytes.
    clear_logs();
    stim = '{8'hA5, 8'h12, 8'h34, 8'h02, 8'hAA, 8'hBB};
    push_stim();
    for (int i = 0; i < TIMEOUT + 200 && err_cnt == 0; i++) begin
      @(posedge CLK); #1;
    end
    repeat (2) @(posedge CLK);
    #1;
    check("to_err", err_cnt, 1);
    check("to_nwr", wr_log.size(), 2);
    check("to_w0", (wr_log.size() > 0) ? 32'(wr_log[0]) : 32'd0, 32'h1234AA);
    check("to_w1", (wr_log.size() > 1) ? 32'(wr_log[1]) : 32'd0, 32'h1235BB);
    check("to_ntx", tx_log.size(), 0);
    check("to_busy", 32'(busy), 32'd0);
    check("to_gap", 32'((err_cyc - last_wr_cyc >= TIMEOUT - 2) &&
                        (err_cyc - last_wr_cyc <= TIMEOUT + 2)), 32'd1);
    stim = '{8'hA5, 8'h12, 8'h34, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'h87};
    run_stream("after_to");

    // enable gates only the start of a frame.
    enable = 1'b0;
    clear_logs();
    model();
    push_stim();
    repeat (30) @(posedge CLK);
    #1;
    check("en_hold", rx_q.size(), 8);
    check("en_idle_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 20 && !busy; i++) begin
      @(posedge CLK); #1;
    end
    check("en_start", 32'(busy), 32'd1);
    enable = 1'b0;
    wait_idle("en");
    compare("en", 0);
    enable = 1'b1;

    // Reply held off by a full TX FIFO.
    tx_full_r = 1'b1;
    clear_logs();
    model();
    push_stim();
    for (int i = 0; i < 200 && (rx_q.size() != 0 || dq.size() != 0); i++) begin
      @(posedge CLK); #1;
    end
    repeat (50) @(posedge CLK);
    #1;
    check("txf_hold", tx_log.size(), 0);
    check("txf_busy", 32'(busy), 32'd1);
    rel = cyc;
    tx_full_r = 1'b0;
    wait_idle("txf");
    compare("txf", 0);
    check("txf_lat", 32'((tx_cyc > rel) && (tx_cyc - rel <= 3)), 32'd1);

    // Reset in the middle of a payload.
    clear_logs();
    stim.delete();
    add_frame(16'h4000, 8'd7, 1'b1);
    push_stim();
    for (int i = 0; i < 300 && wr_log.size() < 3; i++) begin
      @(posedge CLK); #1;
    end
    check("rst_mid_reached", 32'(wr_log.size() >= 3), 32'd1);
    RST = 1'b1;
    #1;
    check_zero("rst_mid");
    @(posedge CLK); #1;
    rx_q.delete();
    dq.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    stim = '{8'hA5, 8'h12, 8'h34, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'h87};
    run_stream("after_rst");

    // Longest payload, crossing the top of the address space.
    stim.delete();
    add_frame(16'hFFF0, 8'hFF, 1'b1);
    run_stream("len256");

    for (int it = 0; it < 12; it++) begin
      stim.delete();
      add_garbage($urandom_range(0, 3));
      add_frame(16'($urandom), 8'($urandom_range(0, 5)), $urandom_range(0, 3) != 0);
      add_garbage($urandom_range(0, 2));
      add_frame(16'($urandom), 8'($urandom_range(0, 5)), $urandom_range(0, 3) != 0);
      run_stream("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
# uart_loader

Frame-decoding responder that sits on the CPU side of the UART wrapper's 16-bit status/data word and read/write strobes. It drains received bytes, hunts for a sync byte, parses a framed memory-write command, streams the payload into a byte-wide memory port, and returns a one-byte ACK/NAK through the transmit FIFO. It is the boot/debug path for loading memory over the serial link without CPU involvement.

## Interface

Parameters:
- ADDR_W, 16: memory address width (≤16); upper address bits beyond ADDR_W are discarded.
- SYNC, 8'hA5: frame start byte.
- ACK, 8'h06: reply on good checksum.
- NAK, 8'h15: reply on bad checksum.
- RD_LAT, 2: cycles from uartRead pulse to valid byte on uartStatus[7:0].
- TIMEOUT, 1000000: idle cycles allowed between bytes inside a frame.

Ports:
- CLK  in  1  system clock; the only clock.
- RST  in  1  asynchronous, active-high reset.
- enable  in  1  permits starting a new frame.
- uartStatus  in  16  wrapper word: [11] RXempty, [10] RXfull, [9] TXempty, [8] TXfull, [7:0] RX byte.
- uartRead  out  1  one-cycle RX FIFO pop.
- uartWrite  out  1  one-cycle TX FIFO push.
- uartData  out  8  byte pushed with uartWrite.
- memAddr  out  ADDR_W  payload write address.
- memData  out  8  payload write data.
- memWrite  out  1  one-cycle memory write strobe.
- busy  out  1  high in any state except HUNT.
- done  out  1  one-cycle pulse after ACK is pushed.
- error  out  1  one-cycle pulse on NAK or timeout.

## Operation

- Frame: SYNC, ADDR_HI, ADDR_LO, LEN, payload (LEN+1 bytes, 1..256), CHK. Valid when (ADDR_HI+ADDR_LO+LEN+payload+CHK) mod 256 == 0.
- Byte fetch (shared by all states): when RXempty==0, pulse uartRead one cycle, wait RD_LAT cycles, sample uartStatus[7:0]. Never pulse uartRead while RXempty==1.
- States:
  - HUNT: fetch only when enable==1; byte==SYNC -> ADDR_HI, else discard and stay. busy=0.
  - ADDR_HI, ADDR_LO: load address, start checksum accumulator with each byte -> next.
  - LEN: load byte counter = LEN -> DATA.
  - DATA: per byte: memAddr=current address, memData=byte, memWrite pulse one cycle; address += 1 mod 2^ADDR_W; accumulate; after counter reaches 0 -> CHK.
  - CHK: accumulate; sum==0 selects ACK else NAK -> REPLY.
  - REPLY: wait while TXfull==1; then push ACK/NAK with uartWrite one cycle; pulse done (ACK) or error (NAK) the same cycle -> HUNT.
- Payload is written as received; a NAK does not roll back memory.
- Timeout: counter cleared on every sampled byte, counts in all states except HUNT and REPLY; reaching TIMEOUT -> error pulse, no reply, -> HUNT.
- enable is checked only in HUNT; deasserting mid-frame does not abort.
- RST (any time, including mid-frame): state HUNT, counters/accumulator cleared, all outputs 0.

## Timing

- Byte fetch costs 1+RD_LAT cycles minimum; back-to-back fetches when RXempty stays 0.
- memWrite asserts the cycle after the data byte is sampled; memAddr/memData held valid that cycle.
- REPLY to uartWrite: 1 cycle if TXfull==0, else first cycle after TXfull falls.
- done/error coincide with uartWrite; HUNT entered next cycle.
- Checksum and address arithmetic are 8-bit and ADDR_W-bit modular, no carry out.

## Test plan

- Good frame A5 12 34 02 AA BB CC 87 -> memWrite at 1234/1235/1236 with AA/BB/CC, uartData=06, done pulse, error 0.
- Same frame with CHK 88 -> identical three writes, uartData=15, error pulse, no done.
- Bytes 00 FF 5A then good frame -> leading bytes discarded, no memWrite before the frame, single ACK.
- Wrap: A5 FF FF 01 11 22 CE -> writes 11@FFFF, 22@0000, ACK.
- Stop after two payload bytes for TIMEOUT cycles (TIMEOUT=100 in bench) -> error pulse, no uartWrite, busy falls; next good frame ACKed.
- TXfull held 1 at REPLY for 50 cycles -> uartWrite only after release; RST asserted mid-payload -> all outputs 0 immediately, next frame parsed from HUNT.
